// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor and its neighbours
// (decode and the ID-stage comparator use the same opcode constants).
package branch_predictor_pkg;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_INIT = CTR_WNT;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and ID-stage resolution signals between the pipeline and the predictor.
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter next-state function (no storage).
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic inc_i,
    output ctr_e ctr_o
);
    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != CTR_ST) ctr_o = ctr_e'(ctr_i + 2'd1);
        end else begin
            if (ctr_i != CTR_SNT) ctr_o = ctr_e'(ctr_i - 2'd1);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, mispredict/redirect generation
// and saturating branch / mispredict counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    branch_predictor_if.slave    bp,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);
    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int ENTRIES  = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]               valid_vec;
    logic [ENTRIES-1:0][TAG_BITS-1:0] tag_vec;
    logic [ENTRIES-1:0][31:0]         target_vec;
    ctr_e                             ctr_vec [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx, upd_idx;
    logic [TAG_BITS-1:0]   if_tag, upd_tag;
    logic                  if_hit, upd_hit;
    ctr_e                  ctr_upd;

    assign if_idx  = bp.if_pc[INDEX_BITS+1:2];
    assign if_tag  = bp.if_pc[31:INDEX_BITS+2];
    assign upd_idx = bp.upd_pc[INDEX_BITS+1:2];
    assign upd_tag = bp.upd_pc[31:INDEX_BITS+2];

    assign if_hit  = valid_vec[if_idx] && (tag_vec[if_idx] == if_tag);
    assign upd_hit = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);

    // Lookup sees registered state only, so a same-cycle update shows up next cycle.
    assign bp.pred_taken  = if_hit && ctr_vec[if_idx][1];
    assign bp.pred_target = bp.pred_taken ? target_vec[if_idx] : pc_plus4(bp.if_pc);

    assign bp.mispredict = bp.upd_valid &&
                           ((bp.upd_taken != bp.upd_pred_taken) ||
                            (bp.upd_taken && bp.upd_pred_taken &&
                             (bp.upd_target != bp.upd_pred_target)));
    assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : pc_plus4(bp.upd_pc);

    sat_counter2 u_sat_counter2 (
        .ctr_i (ctr_vec[upd_idx]),
        .inc_i (bp.upd_taken),
        .ctr_o (ctr_upd)
    );

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                valid_q;
            logic [TAG_BITS-1:0] tag_q;
            logic [31:0]         target_q;
            ctr_e                ctr_q;
            logic                sel;

            assign sel = bp.upd_valid && (upd_idx == INDEX_BITS'(gi));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    valid_q  <= 1'b0;
                    tag_q    <= '0;
                    target_q <= '0;
                    ctr_q    <= CTR_INIT;
                end else if (sel) begin
                    if (upd_hit) begin
                        ctr_q <= ctr_upd;
                        if (bp.upd_taken) target_q <= bp.upd_target;
                    end else if (bp.upd_taken) begin
                        // Taken miss allocates over whatever lived at this index.
                        valid_q  <= 1'b1;
                        tag_q    <= upd_tag;
                        target_q <= bp.upd_target;
                        ctr_q    <= CTR_WT;
                    end
                end
            end

            assign valid_vec[gi]  = valid_q;
            assign tag_vec[gi]    = tag_q;
            assign target_vec[gi] = target_q;
            assign ctr_vec[gi]    = ctr_q;
        end
    endgenerate

    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bp.upd_valid && !(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + 1'b1;
        if (bp.mispredict && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
endmodule
